// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between hps_io, the board CPU read port and the shared BRAM.
// With LOAD_CHECKSUM_EN defined the bundle also carries the 16-bit load_sum.
interface rom_port_arbiter_if #(
    parameter int AW = 16
);
    logic          ioctl_download;
    logic          ioctl_upload;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          core_reset;
    logic [7:0]    mod_id;
    logic [7:0]    dip0;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0]   load_sum;
`endif

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        input  cpu_req, cpu_addr, mem_rdata,
        output ioctl_din, ioctl_wait, cpu_ack, cpu_rdata,
        output mem_addr, mem_we, mem_wdata, core_reset, mod_id, dip0
`ifdef LOAD_CHECKSUM_EN
        , output load_sum
`endif
    );

    modport master (
        output ioctl_download, ioctl_upload, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
        output cpu_req, cpu_addr, mem_rdata,
        input  ioctl_din, ioctl_wait, cpu_ack, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata, core_reset, mod_id, dip0
`ifdef LOAD_CHECKSUM_EN
        , input load_sum
`endif
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one single-port BRAM between the HPS ioctl loader and the board CPU read port,
// and holds the core in reset around transfers. Optional feature macro: LOAD_CHECKSUM_EN.
module rom_port_arbiter #(
    parameter int AW          = 16,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    rom_port_arbiter_if.slave bus
);
    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD1,
        S_RD2,
        S_UP1,
        S_UP2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [7:0]    r_mem_wdata;
    logic          r_wait;
    logic [7:0]    r_ioctl_din;
    logic          r_cpu_ack;
    logic [7:0]    r_cpu_rdata;
    logic          r_core_reset;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_mod_id;
    logic [7:0]    r_dip0;
    logic          r_pend;
    logic [AW-1:0] r_pend_addr;
    logic [7:0]    r_pend_data;
    logic          r_up_seen;
    logic          r_up_oor;
    logic [24:0]   r_up_addr;

    logic          w_transfer;
    logic          w_addr_in_range;
    logic          w_wr_hit;
    logic          w_reg_wr;
    logic          w_issue_wr;
    logic          w_issue_pend;
    logic          w_start_rd;
    logic          w_start_up;
    logic          w_buffer_new;
    logic [7:0]    w_wr_data;

    assign w_transfer      = bus.ioctl_download | bus.ioctl_upload;
    assign w_addr_in_range = (bus.ioctl_addr >> AW) == 25'd0;
    assign w_wr_hit        = bus.ioctl_download & bus.ioctl_wr &
                             (bus.ioctl_index == 8'd0) & w_addr_in_range;
    assign w_reg_wr        = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_addr == 25'd0);
    // A strobe that cannot be issued this cycle parks in the one-entry buffer.
    assign w_buffer_new    = w_wr_hit & ~w_issue_wr;
    assign w_wr_data       = w_issue_pend ? r_pend_data : bus.ioctl_dout;

    always_comb begin
        w_next       = r_state;
        w_issue_wr   = 1'b0;
        w_issue_pend = 1'b0;
        w_start_rd   = 1'b0;
        w_start_up   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    w_issue_pend = 1'b1;
                    w_next       = S_WR;
                end else if (w_wr_hit) begin
                    w_issue_wr = 1'b1;
                    w_next     = S_WR;
                end else if (!w_transfer && bus.cpu_req && !r_cpu_ack) begin
                    w_start_rd = 1'b1;
                    w_next     = S_RD1;
                end else if (bus.ioctl_upload && (!r_up_seen || bus.ioctl_addr != r_up_addr)) begin
                    w_start_up = 1'b1;
                    w_next     = S_UP1;
                end
            end
            S_WR:    w_next = S_IDLE;
            S_RD1:   w_next = S_RD2;
            S_RD2:   w_next = S_IDLE;
            S_UP1:   w_next = S_UP2;
            S_UP2:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= 8'h00;
            r_wait      <= 1'b0;
            r_ioctl_din <= 8'h00;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= 8'h00;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= 8'h00;
            r_up_seen   <= 1'b0;
            r_up_oor    <= 1'b0;
            r_up_addr   <= 25'd0;
        end else begin
            r_state   <= w_next;
            r_mem_we  <= w_issue_wr | w_issue_pend;
            r_wait    <= (w_next == S_WR) || (w_next == S_UP1) || (w_next == S_UP2);
            r_cpu_ack <= (r_state == S_RD2);

            if (w_issue_pend) begin
                r_mem_addr  <= r_pend_addr;
                r_mem_wdata <= w_wr_data;
            end else if (w_issue_wr) begin
                r_mem_addr  <= bus.ioctl_addr[AW-1:0];
                r_mem_wdata <= w_wr_data;
            end else if (w_start_rd) begin
                r_mem_addr <= bus.cpu_addr;
            end else if (w_start_up && w_addr_in_range) begin
                r_mem_addr <= bus.ioctl_addr[AW-1:0];
            end

            if (w_buffer_new) begin
                r_pend      <= 1'b1;
                r_pend_addr <= bus.ioctl_addr[AW-1:0];
                r_pend_data <= bus.ioctl_dout;
            end else if (w_issue_pend) begin
                r_pend <= 1'b0;
            end

            if (r_state == S_RD2) begin
                r_cpu_rdata <= bus.mem_rdata;
            end

            // Out-of-range upload addresses never touch the BRAM and read back as FF.
            if (r_state == S_UP2) begin
                r_ioctl_din <= r_up_oor ? 8'hFF : bus.mem_rdata;
            end

            if (!bus.ioctl_upload) begin
                r_up_seen <= 1'b0;
            end else if (w_start_up) begin
                r_up_seen <= 1'b1;
                r_up_addr <= bus.ioctl_addr;
                r_up_oor  <= ~w_addr_in_range;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mod_id <= 8'hFF;
            r_dip0   <= 8'h00;
        end else if (w_reg_wr) begin
            if (bus.ioctl_index == 8'd1) begin
                r_mod_id <= bus.ioctl_dout;
            end
            if (bus.ioctl_index == 8'd254) begin
                r_dip0 <= bus.ioctl_dout;
            end
        end
    end

    // core_reset stays high through a transfer, then for HOLD_CYCLES more edges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hold       <= HOLD_INIT;
            r_core_reset <= 1'b1;
        end else if (w_transfer) begin
            r_hold       <= HOLD_INIT;
            r_core_reset <= 1'b1;
        end else if (r_hold > HW'(1)) begin
            r_hold <= r_hold - HW'(1);
        end else begin
            r_hold       <= '0;
            r_core_reset <= 1'b0;
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic        r_dl_d;
    logic [15:0] r_sum;
    logic [15:0] w_sum_base;

    assign w_sum_base = (bus.ioctl_download & ~r_dl_d) ? 16'd0 : r_sum;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_d <= 1'b0;
            r_sum  <= 16'd0;
        end else begin
            r_dl_d <= bus.ioctl_download;
            if (w_issue_wr || w_issue_pend) begin
                r_sum <= w_sum_base + {8'h00, w_wr_data};
            end else begin
                r_sum <= w_sum_base;
            end
        end
    end

    assign bus.load_sum = r_sum;
`endif

    assign bus.ioctl_din  = r_ioctl_din;
    assign bus.ioctl_wait = r_wait;
    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.core_reset = r_core_reset;
    assign bus.mod_id     = r_mod_id;
    assign bus.dip0       = r_dip0;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed and randomized loader/CPU traffic
// compared against a byte-array reference model of the ROM image and side registers.
module tb_rom_port_arbiter;
    localparam int AW   = 16;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    rom_port_arbiter_if #(.AW(AW)) bus ();

    rom_port_arbiter #(.AW(AW), .HOLD_CYCLES(HOLD)) dut (
        .clk_sys (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port BRAM with one cycle of read latency.
    logic [7:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= bram[bus.mem_addr];
    end

    int weCount = 0;
    int waitCount = 0;
    int ackCount = 0;
    always @(negedge clk) begin
        if (bus.mem_we) weCount++;
        if (bus.ioctl_wait) waitCount++;
        if (bus.cpu_ack) ackCount++;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  refMem [int];
    logic [7:0]  refMod = 8'hFF;
    logic [7:0]  refDip = 8'h00;
    logic [15:0] refSum = 16'd0;
    int          written[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One loader write strobe plus the reference-model effect of that write.
    task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        tick(1);
        bus.ioctl_wr = 1'b0;
        tick(3);
        if (idx == 8'd0 && addr < 25'(1 << AW)) begin
            refMem[int'(addr)] = data;
            refSum = refSum + {8'h00, data};
        end
        if (addr == 25'd0 && idx == 8'd1) refMod = data;
        if (addr == 25'd0 && idx == 8'd254) refDip = data;
    endtask

    task automatic startDownload();
        bus.ioctl_download = 1'b1;
        refSum = 16'd0;
        tick(1);
    endtask

    task automatic cpuRead(input logic [AW-1:0] a, output logic [7:0] d, output int lat);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!bus.cpu_ack && lat < 20);
        d = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        tick(1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int lat;
        int n;
        int weBefore;
        int waitBefore;
        int ackBefore;
        logic [7:0] v;
        logic [24:0] a;

        bus.ioctl_download = 1'b0;
        bus.ioctl_upload   = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        bus.cpu_req        = 1'b0;
        bus.cpu_addr       = '0;

        tick(3);
        checkOutput("rst ioctl_din", bus.ioctl_din, 8'h00);
        checkOutput("rst ioctl_wait", bus.ioctl_wait, 1'b0);
        checkOutput("rst cpu_ack", bus.cpu_ack, 1'b0);
        checkOutput("rst cpu_rdata", bus.cpu_rdata, 8'h00);
        checkOutput("rst mem_addr", bus.mem_addr, 0);
        checkOutput("rst mem_we", bus.mem_we, 1'b0);
        checkOutput("rst mem_wdata", bus.mem_wdata, 8'h00);
        checkOutput("rst core_reset", bus.core_reset, 1'b1);
        checkOutput("rst mod_id", bus.mod_id, 8'hFF);
        checkOutput("rst dip0", bus.dip0, 8'h00);
        reset_n = 1'b1;
        tick(HOLD + 2);

        $display("[TB] download 4 image bytes");
        startDownload();
        weBefore = weCount;
        waitBefore = waitCount;
        applyStimulus(8'd0, 25'd0, 8'h11);
        applyStimulus(8'd0, 25'd1, 8'h22);
        applyStimulus(8'd0, 25'd2, 8'h33);
        applyStimulus(8'd0, 25'd3, 8'h44);
        checkOutput("image we pulses", weCount - weBefore, 4);
        checkOutput("image wait cycles", waitCount - waitBefore, 4);

        $display("[TB] mod and dip registers");
        weBefore = weCount;
        waitBefore = waitCount;
        applyStimulus(8'd1, 25'd0, 8'h03);
        applyStimulus(8'd254, 25'd0, 8'hA5);
        checkOutput("mod_id", bus.mod_id, refMod);
        checkOutput("dip0", bus.dip0, refDip);
        for (int i = 0; i < 4; i++) begin
            a = 25'($urandom_range(0, 1));
            v = 8'($urandom);
            applyStimulus((i % 2 == 0) ? 8'd1 : 8'd254, a, v);
            checkOutput($sformatf("mod_id rnd%0d", i), bus.mod_id, refMod);
            checkOutput($sformatf("dip0 rnd%0d", i), bus.dip0, refDip);
        end
        checkOutput("reg we pulses", weCount - weBefore, 0);
        checkOutput("reg wait cycles", waitCount - waitBefore, 0);

        weBefore = weCount;
        waitBefore = waitCount;
        applyStimulus(8'd0, 25'(1 << AW), 8'h5C);
        checkOutput("oor we pulses", weCount - weBefore, 0);
        checkOutput("oor wait cycles", waitCount - waitBefore, 0);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("load_sum after oor", bus.load_sum, refSum);
`endif

        ackBefore = ackCount;
        bus.cpu_req = 1'b1;
        bus.cpu_addr = '0;
        tick(6);
        checkOutput("cpu blocked in download", ackCount - ackBefore, 0);
        bus.cpu_req = 1'b0;
        checkOutput("core_reset in download", bus.core_reset, 1'b1);

        bus.ioctl_download = 1'b0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.core_reset && n < 100);
        checkOutput("core_reset hold", n, HOLD);

        cpuRead(AW'(1), d, lat);
        checkOutput("cpu latency", lat, 3);
        checkOutput("cpu data @1", d, 8'h22);
        for (int i = 0; i < 4; i++) begin
            cpuRead(AW'(i), d, lat);
            checkOutput($sformatf("readback @%0d", i), d, refMem[i]);
        end

        $display("[TB] download during CPU read");
        weBefore = weCount;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = AW'(2);
        tick(1);
        bus.ioctl_download = 1'b1;
        refSum = 16'd0;
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = 25'd5;
        bus.ioctl_dout  = 8'h5A;
        bus.ioctl_wr    = 1'b1;
        tick(1);
        bus.ioctl_wr = 1'b0;
        tick(1);
        checkOutput("overlap ack", bus.cpu_ack, 1'b1);
        checkOutput("overlap rdata", bus.cpu_rdata, refMem[2]);
        bus.cpu_req = 1'b0;
        refMem[5] = 8'h5A;
        refSum = refSum + 16'h005A;
        tick(3);
        checkOutput("overlap buffered we", weCount - weBefore, 1);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("load_sum overlap", bus.load_sum, refSum);
`endif

        $display("[TB] randomized download");
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = 25'(1 << AW) + 25'($urandom_range(0, 1000));
            end else begin
                a = 25'($urandom_range(256, 511));
                written.push_back(int'(a));
            end
            applyStimulus(8'd0, a, 8'($urandom));
        end
`ifdef LOAD_CHECKSUM_EN
        checkOutput("load_sum random", bus.load_sum, refSum);
`endif
        bus.ioctl_download = 1'b0;
        tick(HOLD + 2);
        checkOutput("core_reset released", bus.core_reset, 1'b0);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("load_sum stable", bus.load_sum, refSum);
`endif
        cpuRead(AW'(5), d, lat);
        checkOutput("readback @5", d, refMem[5]);
        for (int i = 0; i < 12; i++) begin
            n = written[$urandom_range(0, written.size() - 1)];
            cpuRead(AW'(n), d, lat);
            checkOutput($sformatf("rnd read @%0h", n), d, refMem[n]);
            checkOutput($sformatf("rnd latency @%0h", n), lat, 3);
        end

        $display("[TB] upload");
        waitBefore = waitCount;
        bus.ioctl_addr = 25'd0;
        bus.ioctl_upload = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ioctl_addr = 25'(i);
            tick(6);
            checkOutput($sformatf("upload @%0d", i), bus.ioctl_din, refMem[i]);
        end
        bus.ioctl_addr = 25'(1 << AW) + 25'd3;
        tick(6);
        checkOutput("upload oor", bus.ioctl_din, 8'hFF);
        checkOutput("upload wait cycles", waitCount - waitBefore, 10);
        checkOutput("core_reset in upload", bus.core_reset, 1'b1);
        bus.ioctl_upload = 1'b0;
        tick(HOLD + 2);

        $display("[TB] reset during write");
        startDownload();
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = 25'd1;
        bus.ioctl_dout  = 8'h77;
        bus.ioctl_wr    = 1'b1;
        tick(1);
        checkOutput("we before reset", bus.mem_we, 1'b1);
        reset_n = 1'b0;
        #1;
        refMod = 8'hFF;
        refDip = 8'h00;
        refSum = 16'd0;
        checkOutput("reset mem_we", bus.mem_we, 1'b0);
        checkOutput("reset core_reset", bus.core_reset, 1'b1);
        checkOutput("reset mod_id", bus.mod_id, refMod);
        checkOutput("reset dip0", bus.dip0, refDip);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("reset load_sum", bus.load_sum, refSum);
`endif
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(HOLD + 2);
        cpuRead(AW'(1), d, lat);
        checkOutput("lost write @1", d, refMem[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
